// File: rtl/loop_mon_pkg.sv
// Shared types and constants for the loop invariant monitor.
// The state encoding is visible on the state port, so the values are fixed.
package loop_mon_pkg;

  localparam int unsigned DefaultW = 15;
  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } mon_state_e;

  localparam logic [2:0] FailNone    = 3'd0;
  localparam logic [2:0] FailInv     = 3'd1;
  localparam logic [2:0] FailStep    = 3'd2;
  localparam logic [2:0] FailConst   = 3'd3;
  localparam logic [2:0] FailOverrun = 3'd4;

endpackage

// File: rtl/loop_mon_check.sv
// Combinational invariant checks on one sample, priority-encoded into a fail code.
// Also reports whether the sample is an exact +1 step of the previous index.
module loop_mon_check
  import loop_mon_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         first,
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] y_cur,
  input  logic [W-1:0] x_cur,
  input  logic [W-1:0] prev_i,
  input  logic [W-1:0] prev_y,
  input  logic [W-1:0] prev_x,
  output logic [2:0]   code,
  output logic         inc
);

  logic [W:0] i_ext;
  logic [W:0] prev_inc;
  logic       inv_hit;
  logic       step_hit;
  logic       const_hit;
  logic       overrun_hit;

  // One extra bit so that all-ones + 1 never aliases to 0.
  assign i_ext    = {1'b0, i_cur};
  assign prev_inc = {1'b0, prev_i} + {{W{1'b0}}, 1'b1};
  assign inc      = (i_ext == prev_inc);

  assign inv_hit     = (i_cur < y_cur) && (i_cur >= x_cur);
  assign step_hit    = (i_cur != prev_i) && !inc;
  assign const_hit   = (y_cur != prev_y) || (x_cur != prev_x);
  assign overrun_hit = (i_cur != prev_i) && (prev_i >= prev_y);

  always_comb begin
    code = FailNone;
    if (inv_hit) begin
      code = FailInv;
    end else if (!first) begin
      if (step_hit) begin
        code = FailStep;
      end else if (const_hit) begin
        code = FailConst;
      end else if (overrun_hit) begin
        code = FailOverrun;
      end
    end
  end

endmodule

// File: rtl/loop_invariant_monitor.sv
// Watches a bounded loop counter stream and latches the first invariant violation.
// FSM and all state live here; the checks are in loop_mon_check.
module loop_invariant_monitor
  import loop_mon_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     i_in,
  input  logic [W-1:0]     y_in,
  input  logic [W-1:0]     x_in,
  output logic [1:0]       state,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [W-1:0]     fail_i,
  output logic [CNT_W-1:0] step_cnt,
  output logic             done
);

  mon_state_e       state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [W-1:0]     fail_i_q, fail_i_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     prev_i_q, prev_i_d;
  logic [W-1:0]     prev_y_q, prev_y_d;
  logic [W-1:0]     prev_x_q, prev_x_d;

  logic [2:0] chk_code;
  logic       chk_inc;

  loop_mon_check #(
    .W (W)
  ) u_check (
    .first  (state_q == StIdle),
    .i_cur  (i_in),
    .y_cur  (y_in),
    .x_cur  (x_in),
    .prev_i (prev_i_q),
    .prev_y (prev_y_q),
    .prev_x (prev_x_q),
    .code   (chk_code),
    .inc    (chk_inc)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    fail_i_d = fail_i_q;
    cnt_d    = cnt_q;
    prev_i_d = prev_i_q;
    prev_y_d = prev_y_q;
    prev_x_d = prev_x_q;

    if (clear) begin
      // Soft restart drops any concurrent sample.
      state_d  = StIdle;
      code_d   = FailNone;
      fail_i_d = '0;
      cnt_d    = '0;
      prev_i_d = '0;
      prev_y_d = '0;
      prev_x_d = '0;
    end else if (in_valid && (state_q != StFail)) begin
      if (chk_code != FailNone) begin
        state_d  = StFail;
        code_d   = chk_code;
        fail_i_d = i_in;
      end else begin
        prev_i_d = i_in;
        prev_y_d = y_in;
        prev_x_d = x_in;
        if ((state_q != StIdle) && chk_inc && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (i_in >= y_in) begin
          state_d = StDone;
        end else if (state_q == StIdle) begin
          state_d = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      code_q   <= FailNone;
      fail_i_q <= '0;
      cnt_q    <= '0;
      prev_i_q <= '0;
      prev_y_q <= '0;
      prev_x_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      fail_i_q <= fail_i_d;
      cnt_q    <= cnt_d;
      prev_i_q <= prev_i_d;
      prev_y_q <= prev_y_d;
      prev_x_q <= prev_x_d;
    end
  end

  assign state     = state_q;
  assign fail      = (state_q == StFail);
  assign done      = (state_q == StDone);
  assign fail_code = code_q;
  assign fail_i    = fail_i_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_loop_invariant_monitor.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs, queued and
// compared one edge later against the monitor.
module tb_loop_invariant_monitor;

  localparam int W     = 15;
  localparam int CNT_W = 16;
  localparam int MaxI  = (1 << W) - 1;

  typedef struct {
    logic [1:0]       st;
    logic [2:0]       code;
    logic [W-1:0]     fi;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     i_in = '0;
  logic [W-1:0]     y_in = '0;
  logic [W-1:0]     x_in = '0;
  logic [1:0]       state;
  logic             fail;
  logic [2:0]       fail_code;
  logic [W-1:0]     fail_i;
  logic [CNT_W-1:0] step_cnt;
  logic             done;

  int n_chk = 0;
  int n_err = 0;

  exp_t sb[$];

  // Model state
  int m_st = 0, m_code = 0, m_fi = 0, m_cnt = 0, m_pi = 0, m_py = 0, m_px = 0;

  loop_invariant_monitor #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .i_in      (i_in),
    .y_in      (y_in),
    .x_in      (x_in),
    .state     (state),
    .fail      (fail),
    .fail_code (fail_code),
    .fail_i    (fail_i),
    .step_cnt  (step_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit clr, input bit v, input int i, input int y,
                       input int x);
    int code;
    bit inv;
    if (r || clr) begin
      m_st = 0; m_code = 0; m_fi = 0; m_cnt = 0; m_pi = 0; m_py = 0; m_px = 0;
    end else if (v && m_st != 3) begin
      inv  = (i < y) && (i >= x);
      code = 0;
      if (inv) code = 1;
      else if (m_st != 0) begin
        if (i != m_pi && i != m_pi + 1) code = 2;
        else if (y != m_py || x != m_px) code = 3;
        else if (i != m_pi && m_pi >= m_py) code = 4;
      end
      if (code != 0) begin
        m_st = 3; m_code = code; m_fi = i;
      end else begin
        if (m_st != 0 && i == m_pi + 1 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (i >= y) m_st = 2;
        else if (m_st == 0) m_st = 1;
        m_pi = i; m_py = y; m_px = x;
      end
    end
  endtask

  task automatic drive(input bit r, input bit clr, input bit v, input int i, input int y,
                       input int x);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r; clear = clr; in_valid = v;
    i_in = i[W-1:0]; y_in = y[W-1:0]; x_in = x[W-1:0];
    model(r, clr, v, i, y, x);
    e.st = m_st[1:0]; e.code = m_code[2:0]; e.fi = m_fi[W-1:0]; e.cnt = m_cnt[CNT_W-1:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("state", 32'(state), 32'(g.st));
    check("fail", 32'(fail), 32'(g.st == 2'd3));
    check("done", 32'(done), 32'(g.st == 2'd2));
    check("fail_code", 32'(fail_code), 32'(g.code));
    check("fail_i", 32'(fail_i), 32'(g.fi));
    check("step_cnt", 32'(step_cnt), 32'(g.cnt));
  endtask

  task automatic sample(input int i, input int y, input int x);
    drive(0, 0, 1, i, y, x);
  endtask

  task automatic run(input int from, input int to, input int y, input int x);
    for (int k = from; k <= to; k++) sample(k, y, x);
  endtask

  task automatic do_clear();
    drive(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 3, 9, 9);
    check("reset_state", 32'(state), 32'd0);
    check("reset_cnt", 32'(step_cnt), 32'd0);

    // Clean run to the bound, with idle gaps and repeated final samples.
    run(0, 100, 399, 500);
    drive(0, 0, 0, 77, 1, 1);
    drive(0, 0, 0, 5, 5, 5);
    run(101, 399, 399, 500);
    check("run_done_state", 32'(state), 32'd2);
    check("run_done_cnt", 32'(step_cnt), 32'd399);
    sample(399, 399, 500);
    sample(399, 399, 500);
    sample(400, 399, 500);
    check("overrun_code", 32'(fail_code), 32'd4);

    // Rst while in FAIL.
    drive(1, 1, 1, 0, 399, 500);
    check("rst_in_fail", 32'(fail), 32'd0);

    // INV violation, then later samples ignored.
    run(0, 305, 399, 300);
    check("inv_code", 32'(fail_code), 32'd1);
    check("inv_fail_i", 32'(fail_i), 32'd300);
    do_clear();

    // STEP violation 5 -> 7.
    run(0, 5, 399, 500);
    sample(7, 399, 500);
    sample(8, 399, 500);
    check("step_code", 32'(fail_code), 32'd2);
    do_clear();

    // CONST violation: bound changes at i=10.
    run(0, 9, 399, 500);
    sample(10, 398, 500);
    check("const_code", 32'(fail_code), 32'd3);
    do_clear();

    // Overrun with x=400: INV not met because i>=y.
    run(0, 399, 399, 400);
    sample(400, 399, 400);
    check("overrun_x400", 32'(fail_code), 32'd4);
    do_clear();

    // Clear concurrent with a sample at i=50 drops it; i=50 becomes first sample.
    run(0, 49, 399, 500);
    drive(0, 1, 1, 50, 399, 500);
    check("clear_idle", 32'(state), 32'd0);
    run(50, 52, 399, 500);
    check("clear_restart_cnt", 32'(step_cnt), 32'd2);
    do_clear();

    // Wrap from all-ones to 0 is a STEP violation.
    sample(MaxI, MaxI, MaxI);
    sample(0, MaxI, MaxI);
    check("wrap_code", 32'(fail_code), 32'd2);
    do_clear();

    // Randomised short runs around the bound.
    for (int n = 0; n < 6; n++) begin
      int y, x, i;
      y = int'($urandom_range(5, 20));
      x = int'($urandom_range(3, 25));
      i = 0;
      for (int k = 0; k < 30; k++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) i = i + 2;
        else if (r < 15) i = i + 1;
        if (r == 19) drive(0, 0, 0, i, y, x);
        else sample(i, (r == 18) ? y + 1 : y, x);
      end
      do_clear();
    end

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/loop_invariant_monitor.md
LOOP_INVARIANT_MONITOR -- requirements
Module: loop_invariant_monitor

Interface
REQ-001 The block SHALL have parameter W, default 15, giving the width of the i/y/x operands.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the step counter.
REQ-003 Port clk, input, 1, clock; all logic SHALL be clocked on the rising edge of clk.
REQ-004 Port rst, input, 1, reset; rst SHALL be synchronous and active-high.
REQ-005 Port clear, input, 1, synchronous soft restart of monitoring.
REQ-006 Port in_valid, input, 1, qualifies a sample on i_in/y_in/x_in.
REQ-007 Port i_in, input, W, loop index from the upstream bounded counter stage.
REQ-008 Port y_in, input, W, loop bound.
REQ-009 Port x_in, input, W, invariant ceiling.
REQ-010 Port state, output, 2, current FSM state (IDLE=0, RUN=1, DONE=2, FAIL=3).
REQ-011 Port fail, output, 1, sticky violation flag.
REQ-012 Port fail_code, output, 3, cause of the first violation; 0 means none.
REQ-013 Port fail_i, output, W, i_in value of the failing sample.
REQ-014 Port step_cnt, output, CNT_W, count of accepted increments of i.
REQ-015 Port done, output, 1, high while state is DONE.

Function
REQ-016 A sample SHALL be accepted on each rising edge where in_valid=1, clear=0 and rst=0; with in_valid=0, all state and outputs SHALL hold.
REQ-017 The first sample accepted in IDLE SHALL be captured into prev_i/prev_y/prev_x, and only the INV check SHALL apply to it.
REQ-018 After the first sample, the FSM SHALL enter DONE if i_in>=y_in, otherwise RUN.
REQ-019 The INV check SHALL flag (i_in<y_in) AND (i_in>=x_in) as code 1.
REQ-020 In RUN/DONE, the STEP check SHALL flag i_in differing from both prev_i and prev_i+1 as code 2; prev_i+1 SHALL be computed at W+1 bits, so a wrap from all-ones to 0 is a violation.
REQ-021 In RUN/DONE, the CONST check SHALL flag y_in!=prev_y or x_in!=prev_x as code 3.
REQ-022 In RUN/DONE, the OVERRUN check SHALL flag i_in!=prev_i while prev_i>=prev_y as code 4.
REQ-023 When several checks fire on the same sample, the reported code SHALL follow the priority INV > STEP > CONST > OVERRUN.
REQ-024 Any violation SHALL move the FSM to FAIL and latch fail=1, fail_code and fail_i on the same edge that accepts the sample (one-cycle latency from the sample to the outputs).
REQ-025 FAIL SHALL be absorbing; further samples SHALL be ignored and fail_code/fail_i SHALL not be overwritten.
REQ-026 RUN SHALL transition to DONE when an accepted sample with no violation has i_in>=y_in.
REQ-027 DONE SHALL remain DONE on clean samples.
REQ-028 Each clean accepted sample in RUN/DONE SHALL update prev_* registers.
REQ-029 step_cnt SHALL increment when i_in==prev_i+1 on a clean sample and SHALL saturate at all-ones.
REQ-030 Asserting clear SHALL return the block to IDLE with all outputs at their reset values; clear SHALL win over a simultaneous in_valid, and that sample SHALL be dropped.

Reset
REQ-031 On rst, the block SHALL reset to: state=IDLE, fail=0, fail_code=0, fail_i=0, step_cnt=0, done=0, prev_*=0.
REQ-032 rst SHALL override clear and in_valid, including while in FAIL or mid-run.

Structure
REQ-033 The package loop_mon_pkg SHALL hold the state enum, the fail-code constants (NONE=0, INV=1, STEP=2, CONST=3, OVERRUN=4) and the default W.
REQ-034 The checks and the priority encoding SHALL live in one combinational sub-module, loop_mon_check; the FSM and registers SHALL remain in loop_invariant_monitor.

Verification
REQ-035 Start (i=0, y=399, x=500), increment i once per cycle to 399 -> RUN then DONE at i=399, step_cnt=399, fail=0.
REQ-036 Start (i=0, y=399, x=300), increment i -> at i=300, fail=1, fail_code=1, fail_i=300, state=FAIL; later samples are ignored.
REQ-037 Run with i jumping 5->7 -> fail_code=2, fail_i=7; a separate run with y changing 399->398 at i=10 -> fail_code=3.
REQ-038 Hold i=399 with y=399, then present i=400 -> fail_code=4; with x=400 on the same sample, fail_code=4 (INV is not met since i>=y).
REQ-039 Assert clear at i=50 concurrently with in_valid -> state=IDLE, step_cnt=0; the next sample i=50 is accepted as the first sample.
REQ-040 Assert rst while in FAIL -> all outputs return to reset values on the next edge.
